// File: rtl/ssio_ddr_out_tx.sv
// ssio_ddr_out_tx
// Transmit side of the source-synchronous DDR link. Words of 2*WIDTH bits
// arrive on a valid/ready handshake, sit in a small FIFO and are split into
// rising/falling-edge halves for the data ODDRs. A start-up sequencer brings
// the forwarded clock up before data is accepted. An independent tap-load
// sequencer drives the output-delay primitive's en_vtc/load/cnt_value pins.
module ssio_ddr_out_tx #(
    parameter int               WIDTH             = 1,
    parameter int               DEPTH             = 4,
    parameter logic [WIDTH-1:0] IDLE_PATTERN      = {WIDTH{1'b0}},
    parameter int               CLK_START_CYCLES  = 8,
    parameter int               DATA_START_CYCLES = 4,
    parameter int               VTC_SETTLE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WIDTH-1:0]     oddr_d1,
    output logic [WIDTH-1:0]     oddr_d2,
    output logic                 oddr_clk_d1,
    output logic                 oddr_clk_d2,
    output logic                 tx_active,
    input  logic                 dly_req,
    input  logic [8:0]           dly_value,
    output logic                 dly_busy,
    output logic                 dly_done,
    output logic                 en_vtc,
    output logic                 load,
    output logic [8:0]           cnt_value_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Counter terminal values; all counters are 16 bits wide.
    localparam logic [15:0] CLK_LAST    = 16'(CLK_START_CYCLES - 1);
    localparam logic [15:0] DATA_LAST   = 16'(DATA_START_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(VTC_SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SU_WAIT_CLK  = 2'd0,
        SU_WAIT_DATA = 2'd1,
        SU_RUN       = 2'd2
    } su_state_t;

    typedef enum logic [1:0] {
        DL_IDLE    = 2'd0,
        DL_VTC_OFF = 2'd1,
        DL_LOAD    = 2'd2,
        DL_SETTLE  = 2'd3
    } dl_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    su_state_t          su_state_r;
    logic [15:0]        su_cnt_r;
    logic               clk_d1_r;
    logic               clk_d2_r;
    logic               tx_ready_r;

    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;

    logic [WIDTH-1:0]   d1_r;
    logic [WIDTH-1:0]   d2_r;
    logic               active_r;

    dl_state_t          dl_state_r;
    logic [15:0]        dl_cnt_r;
    logic               dly_busy_r;
    logic               dly_done_r;
    logic               en_vtc_r;
    logic               load_r;
    logic [8:0]         cnt_value_r;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic               run_s;
    logic               empty_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic [PW-1:0]      wr_ptr_next_s;
    logic [PW-1:0]      rd_ptr_next_s;
    logic               full_next_s;

    // Handshake qualifiers and next-cycle pointer view; ready is registered,
    // so fullness is judged on the pointers as they will be after this edge.
    always_comb begin
        run_s         = (su_state_r == SU_RUN);
        empty_s       = (wr_ptr_r == rd_ptr_r);
        wr_en_s       = tx_valid && tx_ready_r;
        rd_en_s       = run_s && !empty_s;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        if (wr_en_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (rd_en_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        full_next_s = (wr_ptr_next_s[AW] != rd_ptr_next_s[AW]) &&
                      (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);
    end

    // Start-up sequencer: hold the forwarded clock low, then run it, then open the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            su_state_r <= SU_WAIT_CLK;
            su_cnt_r   <= 16'd0;
            clk_d1_r   <= 1'b0;
            clk_d2_r   <= 1'b0;
            tx_ready_r <= 1'b0;
        end else begin
            clk_d2_r <= 1'b0;
            case (su_state_r)
                SU_WAIT_CLK: begin
                    tx_ready_r <= 1'b0;
                    if (su_cnt_r == CLK_LAST) begin
                        su_state_r <= SU_WAIT_DATA;
                        su_cnt_r   <= 16'd0;
                        clk_d1_r   <= 1'b1;
                    end else begin
                        su_cnt_r   <= su_cnt_r + 16'd1;
                        clk_d1_r   <= 1'b0;
                    end
                end
                SU_WAIT_DATA: begin
                    clk_d1_r <= 1'b1;
                    if (su_cnt_r == DATA_LAST) begin
                        su_state_r <= SU_RUN;
                        su_cnt_r   <= 16'd0;
                        tx_ready_r <= !full_next_s;
                    end else begin
                        su_cnt_r   <= su_cnt_r + 16'd1;
                        tx_ready_r <= 1'b0;
                    end
                end
                SU_RUN: begin
                    clk_d1_r   <= 1'b1;
                    tx_ready_r <= !full_next_s;
                end
                default: begin
                    su_state_r <= SU_WAIT_CLK;
                    su_cnt_r   <= 16'd0;
                    clk_d1_r   <= 1'b0;
                    tx_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the write pointer passes them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= tx_data;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    // FIFO pointers; reset empties the FIFO and drops any queued words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
        end
    end

    // Output register: pop one word per cycle into the ODDR halves, else drive idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r     <= IDLE_PATTERN;
            d2_r     <= IDLE_PATTERN;
            active_r <= 1'b0;
        end else if (rd_en_s) begin
            d1_r     <= mem_r[rd_ptr_r[AW-1:0]][WIDTH-1:0];
            d2_r     <= mem_r[rd_ptr_r[AW-1:0]][2*WIDTH-1:WIDTH];
            active_r <= 1'b1;
        end else begin
            d1_r     <= IDLE_PATTERN;
            d2_r     <= IDLE_PATTERN;
            active_r <= 1'b0;
        end
    end

    // Tap-load sequencer: drop en_vtc, settle, pulse load, settle, restore en_vtc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_state_r  <= DL_IDLE;
            dl_cnt_r    <= 16'd0;
            dly_busy_r  <= 1'b0;
            dly_done_r  <= 1'b0;
            en_vtc_r    <= 1'b1;
            load_r      <= 1'b0;
            cnt_value_r <= 9'd0;
        end else begin
            case (dl_state_r)
                DL_IDLE: begin
                    dly_done_r <= 1'b0;
                    load_r     <= 1'b0;
                    dl_cnt_r   <= 16'd0;
                    if (dly_req) begin
                        dl_state_r  <= DL_VTC_OFF;
                        cnt_value_r <= dly_value;
                        dly_busy_r  <= 1'b1;
                        en_vtc_r    <= 1'b0;
                    end else begin
                        dly_busy_r  <= 1'b0;
                        en_vtc_r    <= 1'b1;
                    end
                end
                DL_VTC_OFF: begin
                    dly_done_r <= 1'b0;
                    if (dl_cnt_r == SETTLE_LAST) begin
                        dl_state_r <= DL_LOAD;
                        dl_cnt_r   <= 16'd0;
                        load_r     <= 1'b1;
                    end else begin
                        dl_cnt_r   <= dl_cnt_r + 16'd1;
                        load_r     <= 1'b0;
                    end
                end
                DL_LOAD: begin
                    dl_state_r <= DL_SETTLE;
                    dl_cnt_r   <= 16'd0;
                    load_r     <= 1'b0;
                end
                DL_SETTLE: begin
                    if (dl_cnt_r == SETTLE_LAST) begin
                        dl_state_r <= DL_IDLE;
                        dl_cnt_r   <= 16'd0;
                        en_vtc_r   <= 1'b1;
                        dly_done_r <= 1'b1;
                        dly_busy_r <= 1'b0;
                    end else begin
                        dl_cnt_r   <= dl_cnt_r + 16'd1;
                    end
                end
                default: begin
                    dl_state_r <= DL_IDLE;
                    dl_cnt_r   <= 16'd0;
                    dly_busy_r <= 1'b0;
                    dly_done_r <= 1'b0;
                    en_vtc_r   <= 1'b1;
                    load_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready     = tx_ready_r;
    assign oddr_d1      = d1_r;
    assign oddr_d2      = d2_r;
    assign oddr_clk_d1  = clk_d1_r;
    assign oddr_clk_d2  = clk_d2_r;
    assign tx_active    = active_r;
    assign dly_busy     = dly_busy_r;
    assign dly_done     = dly_done_r;
    assign en_vtc       = en_vtc_r;
    assign load         = load_r;
    assign cnt_value_in = cnt_value_r;

endmodule

// File: tb/tb_ssio_ddr_out_tx.sv
// Scoreboard bench for ssio_ddr_out_tx (WIDTH=4, other parameters default).
// Stimulus pushes the expected ODDR halves and the cycle they must appear;
// an independent monitor pops and compares whenever tx_active is high.
module tb_ssio_ddr_out_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] oddr_d1;
    logic [3:0] oddr_d2;
    logic       oddr_clk_d1;
    logic       oddr_clk_d2;
    logic       tx_active;
    logic       dly_req;
    logic [8:0] dly_value;
    logic       dly_busy;
    logic       dly_done;
    logic       en_vtc;
    logic       load;
    logic [8:0] cnt_value_in;

    ssio_ddr_out_tx #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .oddr_d1(oddr_d1), .oddr_d2(oddr_d2),
        .oddr_clk_d1(oddr_clk_d1), .oddr_clk_d2(oddr_clk_d2),
        .tx_active(tx_active), .dly_req(dly_req), .dly_value(dly_value),
        .dly_busy(dly_busy), .dly_done(dly_done), .en_vtc(en_vtc),
        .load(load), .cnt_value_in(cnt_value_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        int         at_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented word must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_active) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h/%0h expected=none (cycle %0d)",
                             oddr_d1, oddr_d2, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("word_d1", 32'(oddr_d1), 32'(e.d1));
                    chk("word_d2", 32'(oddr_d2), 32'(e.d2));
                    chk("word_cycle", 32'(cyc), 32'(e.at_cyc));
                end
            end else begin
                chk("idle_d1", 32'(oddr_d1), 32'h0);
                chk("idle_d2", 32'(oddr_d2), 32'h0);
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_tx_ready", 32'(tx_ready), 32'h0);
        chk("rst_d1", 32'(oddr_d1), 32'h0);
        chk("rst_d2", 32'(oddr_d2), 32'h0);
        chk("rst_clk_d1", 32'(oddr_clk_d1), 32'h0);
        chk("rst_clk_d2", 32'(oddr_clk_d2), 32'h0);
        chk("rst_active", 32'(tx_active), 32'h0);
        chk("rst_busy", 32'(dly_busy), 32'h0);
        chk("rst_done", 32'(dly_done), 32'h0);
        chk("rst_en_vtc", 32'(en_vtc), 32'h1);
        chk("rst_load", 32'(load), 32'h0);
        chk("rst_cnt_value", 32'(cnt_value_in), 32'h0);
    endtask

    // Called at the negedge where rst_n is released; cycle c = edges since release.
    task automatic check_startup();
        for (int c = 0; c < 16; c++) begin
            chk("su_clk_d1", 32'(oddr_clk_d1), 32'(c >= 8));
            chk("su_clk_d2", 32'(oddr_clk_d2), 32'h0);
            chk("su_tx_ready", 32'(tx_ready), 32'(c >= 12));
            chk("su_active", 32'(tx_active), 32'h0);
            @(negedge clk);
        end
    endtask

    // Present one word at a negedge; it is taken on the next posedge.
    task automatic send_word(input logic [7:0] w);
        int   n;
        exp_t e;
        n = 0;
        while (!tx_ready && n < 50) begin
            tx_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            chk("ready_timeout", 32'(tx_ready), 32'h1);
        end else begin
            tx_valid = 1'b1;
            tx_data  = w;
            e.d1     = w[3:0];
            e.d2     = w[7:4];
            e.at_cyc = (cyc + 2 > last_out + 1) ? cyc + 2 : last_out + 1;
            last_out = e.at_cyc;
            sb_q.push_back(e);
            @(negedge clk);
        end
    endtask

    // Tap load of 0x12B with a second request injected while busy.
    task automatic run_dly_seq();
        dly_req   = 1'b1;
        dly_value = 9'h12B;
        @(negedge clk);
        dly_req = 1'b0;
        for (int j = 0; j < 23; j++) begin
            chk("dly_en_vtc", 32'(en_vtc), 32'(j > 20));
            chk("dly_load", 32'(load), 32'(j == 10));
            chk("dly_done", 32'(dly_done), 32'(j == 21));
            chk("dly_busy", 32'(dly_busy), 32'(j <= 20));
            chk("dly_cnt_value", 32'(cnt_value_in), 32'h12B);
            if (j == 5) begin
                dly_req   = 1'b1;
                dly_value = 9'h055;
            end else begin
                dly_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        dly_req   = 1'b0;
        dly_value = 9'h000;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        check_startup();

        // Two back-to-back words
        send_word(8'hA5);
        send_word(8'h3C);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Depth-stress burst of 16 words
        for (int i = 0; i < 16; i++) send_word(8'(i * 29 + 7));
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Tap load concurrent with a data stream
        fork
            begin
                for (int i = 0; i < 12; i++) send_word(8'(i * 53 + 17));
                tx_valid = 1'b0;
            end
            run_dly_seq();
        join
        repeat (6) @(negedge clk);

        // Reset mid-burst with words still in flight
        send_word(8'h91);
        send_word(8'h62);
        send_word(8'hE4);
        tx_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_startup();
        repeat (8) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssio_ddr_out_tx.md
Name: ssio_ddr_out_tx

Overview:
- Transmit-side counterpart of the source-synchronous DDR input path.
- Accepts 2×WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Each cycle it drives registered rising/falling-edge halves (d1/d2) plus a forwarded-clock pattern to the ODDR/output-delay primitives.
- Sequences clock-forwarding start-up after reset, and runs the output-delay tap-load handshake (en_vtc/load/cnt_value).

Parameters:
WIDTH, 1, data lanes per edge.
DEPTH, 4, FIFO entries; power of two, ≥2.
IDLE_PATTERN, 0, WIDTH-bit value driven on both edges when no data is transmitted.
CLK_START_CYCLES, 8, cycles after reset release before the forwarded clock toggles.
DATA_START_CYCLES, 4, cycles after clock start before tx_ready may assert.
VTC_SETTLE_CYCLES, 10, wait between en_vtc deassert and load, and after load.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
tx_data  input  2*WIDTH  [WIDTH-1:0] = rising-edge half, [2*WIDTH-1:WIDTH] = falling-edge half.
tx_valid  input  1  word valid.
tx_ready  output  1  FIFO can accept; transfer when valid&&ready.
oddr_d1  output  WIDTH  rising-edge data to ODDR.
oddr_d2  output  WIDTH  falling-edge data to ODDR.
oddr_clk_d1  output  1  forwarded-clock ODDR rising input.
oddr_clk_d2  output  1  forwarded-clock ODDR falling input.
tx_active  output  1  oddr_d1/d2 carry FIFO data this cycle (not idle).
dly_req  input  1  request tap load; sampled only when dly_busy=0.
dly_value  input  9  tap value, captured with dly_req.
dly_busy  output  1  tap sequence in progress.
dly_done  output  1  one-cycle pulse at sequence end.
en_vtc  output  1  to delay primitive.
load  output  1  to delay primitive.
cnt_value_in  output  9  to delay primitive.

Behaviour:
- Reset values (rst_n low, async):
  - tx_ready=0, oddr_d1=oddr_d2=IDLE_PATTERN, oddr_clk_d1=oddr_clk_d2=0, tx_active=0.
  - dly_busy=0, dly_done=0, en_vtc=1, load=0, cnt_value_in=0.
  - FIFO empty; all counters 0.
- Start-up FSM (WAIT_CLK -> WAIT_DATA -> RUN):
  - WAIT_CLK: count CLK_START_CYCLES; clock pattern 0/0.
  - WAIT_DATA: clock pattern d1=1, d2=0; count DATA_START_CYCLES.
  - RUN: clock pattern 1/0 permanently; tx_ready = !full.
- FIFO:
  - Write on tx_valid&&tx_ready. Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full = MSBs differ && low bits equal; empty = pointers equal.
  - Simultaneous read and write when full is legal only via the registered ready: tx_ready is low when full, so the write is not accepted; no bypass.
- Output register: each cycle in RUN:
  - FIFO non-empty: pop one word; next cycle oddr_d1=low half, oddr_d2=high half, tx_active=1.
  - FIFO empty: IDLE_PATTERN on both edges, tx_active=0.
  - Latency tx accept -> oddr_d* = 2 cycles when the FIFO was empty.
  - Back-to-back words stream at one per cycle with no idle gaps.
- Delay FSM (IDLE -> VTC_OFF -> LOAD -> SETTLE -> IDLE):
  - IDLE: dly_req=1 captures dly_value into cnt_value_in; dly_busy=1.
  - VTC_OFF: en_vtc=0; wait VTC_SETTLE_CYCLES.
  - LOAD: load=1 for exactly 1 cycle.
  - SETTLE: wait VTC_SETTLE_CYCLES, then en_vtc=1, dly_done pulse, dly_busy=0.
  - dly_req while busy is ignored; cnt_value_in holds until the next accepted request.
  - The delay FSM runs independently of the start-up FSM and data path; data continues during tap change.
- Reset mid-operation: immediate return to reset values; FIFO contents discarded; start-up restarts from WAIT_CLK.

Test Plan:
- Reset release, WIDTH=4, defaults -> clock pattern 0/0 for cycles 0..7, 1/0 from cycle 8; tx_ready first high at cycle 12.
- Send 0xA5 then 0x3C back-to-back after ready -> oddr_d1/d2 = 5/A then C/3 on consecutive cycles, tx_active high 2 cycles, then idle 0/0.
- Hold tx_valid with oddr path stalled not possible; instead write 4 words in 4 cycles while draining -> no drop; verify with a depth-stress burst of 16 words.
- dly_req with dly_value=0x12B -> en_vtc low 10 cycles, load 1-cycle pulse with cnt_value_in=0x12B, en_vtc high after 10 more cycles, dly_done single pulse; second dly_req during busy ignored.
- Assert rst_n low mid-burst with 3 words queued -> outputs to IDLE immediately; after release no stale word appears and start-up repeats.
- Simultaneous dly_req and data stream -> data sequence unchanged, cycle-exact.
